// File: rtl/uart_tx_core.sv
// uart_tx_core: valid/ready UART transmitter with programmable baud, width, parity and stop bits.
// All outputs are registered; the next line value is computed from the next state.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 ftdi_tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_next;
    logic [BW-1:0]        baud;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tick, hs, last_data, last_stop, line_next;

    assign tick      = baud == BW'(CLKS_PER_BIT - 1);
    assign hs        = state == IDLE && tx_ready && tx_valid;
    assign last_data = bit_idx == 4'(DATA_BITS - 1);
    assign last_stop = bit_idx == 4'(STOP_BITS - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = hs ? START : IDLE;
            START:   state_next = tick ? DATA : START;
            DATA:    state_next = !(tick && last_data) ? DATA : (PARITY != 0 ? PAR : STOP);
            PAR:     state_next = tick ? STOP : PAR;
            STOP:    state_next = (tick && last_stop) ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
    end

    // shreg[0] is the bit on the line during DATA, so the following bit is shreg[1]
    always_comb begin
        line_next = state_next == IDLE  ? 1'b1 :
                    state_next == START ? 1'b0 :
                    !tick               ? ftdi_tx :
                    state_next == DATA  ? (state == START ? shreg[0] : shreg[1]) :
                    state_next == PAR   ? par_bit : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ftdi_tx  <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            baud    <= (state == IDLE || tick) ? '0 : baud + 1'b1;
            bit_idx <= state_next != state ? '0 : tick ? bit_idx + 1'b1 : bit_idx;
            if (hs) begin
                shreg   <= tx_data;
                par_bit <= PARITY == 1 ? ~^tx_data : ^tx_data;
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
            end
            ftdi_tx  <= line_next;
            tx_ready <= state_next == IDLE;
            tx_busy  <= state_next != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: drives four differently configured transmitters and compares every
// cycle of line/busy/ready against a frame-level model built from queued bit periods.
module tb_uart_tx_core;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : inst
        // 8N1/4, 8O1/3, 7E2/5, 8E1/2
        localparam int C  = g == 0 ? 4 : g == 1 ? 3 : g == 2 ? 5 : 2;
        localparam int DB = g == 2 ? 7 : 8;
        localparam int PM = g == 0 ? 0 : g == 1 ? 1 : 2;
        localparam int SB = g == 2 ? 2 : 1;
        localparam int F  = 1 + DB + (PM != 0 ? 1 : 0) + SB;

        logic       rst_n = 1'b0;
        logic       vld   = 1'b0;
        logic [8:0] din   = '0;
        logic       line, rdy, bsy;
        logic       mon = 1'b0;

        bit   q[$];
        logic e_line = 1'b1, e_bsy = 1'b0, e_rdy = 1'b0;
        int   n_hs = 0;

        uart_tx_core #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .PARITY(PM), .STOP_BITS(SB)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (din[DB-1:0]),
            .tx_valid (vld),
            .tx_ready (rdy),
            .tx_busy  (bsy),
            .ftdi_tx  (line)
        );

        initial forever begin
            @(negedge clk);
            if (mon) begin
                check($sformatf("i%0d line/busy/ready", g), {29'd0, line, bsy, rdy}, {29'd0, e_line, e_bsy, e_rdy});
                if (!rst_n) begin
                    q.delete();
                    {e_line, e_bsy, e_rdy} = 3'b100;
                end else if (q.size() == 0 && e_rdy && vld) begin
                    int ones;
                    n_hs++;
                    ones = $countones(din[DB-1:0]);
                    for (int k = 0; k < F; k++) begin
                        bit b;
                        if (k == 0)                         b = 1'b0;
                        else if (k <= DB)                   b = din[k-1];
                        else if (PM != 0 && k == DB + 1)    b = PM == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
                        else                                b = 1'b1;
                        repeat (C) q.push_back(b);
                    end
                    e_line = q.pop_front();
                    e_bsy = 1'b1;
                    e_rdy = 1'b0;
                end else if (q.size() != 0) begin
                    e_line = q.pop_front();
                    e_bsy = 1'b1;
                    e_rdy = 1'b0;
                end else begin
                    {e_line, e_bsy, e_rdy} = 3'b101;
                end
            end
        end

        task automatic wait_hs(input int h);
            int i;
            for (i = 0; i < 4 * F * C + 10; i++) begin
                @(posedge clk);
                #1;
                if (n_hs != h) break;
            end
            if (n_hs == h) check($sformatf("i%0d handshake timeout", g), 32'(n_hs), 32'(h + 1));
        endtask

        task automatic send(input logic [8:0] w);
            din = w;
            vld = 1'b1;
            wait_hs(n_hs);
            vld = 1'b0;
        endtask

        task automatic wait_idle();
            int i;
            for (i = 0; i < 4 * F * C + 10; i++) begin
                @(posedge clk);
                #1;
                if (q.size() == 0 && e_rdy) break;
            end
            if (!(q.size() == 0 && e_rdy)) check($sformatf("i%0d idle timeout", g), 32'(q.size()), 32'd0);
        endtask

        task automatic pulse_reset();
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        endtask

        initial begin
            @(posedge clk);
            #1 mon = 1'b1;
            @(posedge clk);
            #1 rst_n = 1'b1;
            wait_idle();
            send(9'h047); wait_idle();
            send(9'h001); wait_idle();
            send(9'h0D5); wait_idle();
            // back-to-back with valid held high across both words
            din = 9'h0A5;
            vld = 1'b1;
            wait_hs(n_hs);
            din = 9'h03C;
            wait_hs(n_hs);
            vld = 1'b0;
            wait_idle();
            // reset during data bit 3
            send(9'h0FF);
            repeat (4 * C) @(posedge clk);
            #1 pulse_reset();
            wait_idle();
            send(9'h000); wait_idle();
            // input noise while busy
            send(9'h03A);
            repeat (F * C / 2) begin
                @(posedge clk);
                #1 din = 9'($urandom);
                vld = 1'($urandom);
            end
            vld = 1'b0;
            wait_idle();
            repeat (30) begin
                send(9'($urandom));
                if ($urandom_range(0, 2) == 0) wait_idle();
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, F * C)) @(posedge clk);
                    #1 pulse_reset();
                end
            end
            wait_idle();
            repeat (3) @(posedge clk);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 50000 && done_cnt < NI; i++) @(posedge clk);
        if (done_cnt < NI) check("all instances done", 32'(done_cnt), 32'(NI));
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter that serialises words from a valid/ready source onto `ftdi_tx` at a programmable baud rate. It supports configurable data width, optional odd/even parity and one or two stop bits. It replaces the fixed-pattern, one-bit-per-clock transmitter in the iCE40 UART tester, sitting between the test-pattern/command logic and the FTDI bridge pin.

## Interface
- `CLKS_PER_BIT`, default 104. Clock cycles per bit period (12 MHz / 115200). Legal values are 2 and above.
- `DATA_BITS`, default 8. Data bits per frame. Legal range is 5..9.
- `PARITY`, default 0. Parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1. Number of stop bits: 1 or 2.

- `clk`  in  1  single system clock. All logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tx_data`  in  DATA_BITS  word to send. Sampled only on handshake.
- `tx_valid`  in  1  source has a word on `tx_data`.
- `tx_ready`  out  1  block can accept a word this cycle. Registered.
- `tx_busy`  out  1  a frame is in progress. Registered.
- `ftdi_tx`  out  1  serial line, idle high. Registered; no combinational path from inputs.

## Operation
- States:
  - IDLE → START → DATA → (PARITY if `PARITY`≠0) → STOP → IDLE.
- IDLE:
  - `ftdi_tx`=1, `tx_ready`=1, `tx_busy`=0.
  - Handshake occurs when `tx_valid` && `tx_ready` at a rising edge.
  - On that edge: latch `tx_data` into the shift register, compute the parity bit, clear the baud and bit counters, go to START, drive `ftdi_tx`=0, `tx_ready`=0, `tx_busy`=1.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1; width is $clog2(`CLKS_PER_BIT`).
  - A bit period ends on the edge where the counter equals `CLKS_PER_BIT`-1. On that edge the counter wraps to 0 and the next bit value is registered onto `ftdi_tx`.
- START: one bit period of 0.
- DATA:
  - `DATA_BITS` periods, LSB first.
  - Bit index runs 0..`DATA_BITS`-1; leave DATA after index `DATA_BITS`-1.
- PARITY:
  - One period.
  - Odd mode sends ~^data, so the total count of ones is odd.
  - Even mode sends ^data.
- STOP:
  - `STOP_BITS` periods of 1.
  - At the end of the last stop period: go to IDLE, `tx_ready`=1, `tx_busy`=0, `ftdi_tx` stays 1.
- Input behaviour while busy:
  - `tx_data` and `tx_valid` are ignored.
  - The latched word is not affected by input changes.
- Unused/illegal state encodings return to IDLE on the next edge with `ftdi_tx`=1.

## Timing
- Reset values (while `rst_n`=0 at an edge):
  - state=IDLE, `ftdi_tx`=1, `tx_ready`=0, `tx_busy`=0, counters=0.
  - `tx_ready` rises on the first edge with `rst_n`=1.
- Handshake at edge N:
  - `ftdi_tx` is low from cycle N+1 through N+`CLKS_PER_BIT`.
  - Every bit is held exactly `CLKS_PER_BIT` cycles.
- Frame length: F = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` bit periods.
- Timing of the frame end:
  - `tx_ready` returns high at edge N + F·`CLKS_PER_BIT`.
  - The earliest next handshake is that same edge's following cycle, so the minimum start-to-start spacing is F·`CLKS_PER_BIT`+1 cycles.
  - The extra cycle is idle-high.
- `tx_valid` held high continuously: frames go back-to-back at that spacing with no lost or duplicated words.
- Reset mid-frame:
  - The frame aborts at that edge and `ftdi_tx`=1 from the next cycle.
  - The word is discarded; there is no resume.
- Handshake is only possible in IDLE. There is no simultaneous accept and finish.

## Test plan
- 8N1 `CLKS_PER_BIT`=4, send 0x47:
  - `ftdi_tx` sequence 0,1,1,1,0,0,0,1,0,1, each held 4 cycles (40 cycles).
  - `tx_ready` back high at cycle 40 after the handshake.
- 8E1 and 8O1 with 0x47 (four ones):
  - Even mode parity bit = 0; odd mode parity bit = 1.
  - Frame is 11 periods.
  - 0x01 in even mode gives parity = 1.
- 7N2 `DATA_BITS`=7, `STOP_BITS`=2, send 0x55:
  - Sequence 0,1,0,1,0,1,0,1,1,1.
  - Frame is 10 periods; bit 7 of the input is ignored.
- Back-to-back, `tx_valid` held high with 0xA5 then 0x3C:
  - Both frames are correct.
  - Exactly one idle-high cycle separates stop and the next start.
  - Exactly two handshakes occur.
- Reset mid-DATA (assert `rst_n`=0 during bit 3 of 0xFF):
  - `ftdi_tx`=1, `tx_busy`=0, `tx_ready`=0 on the next cycle.
  - `tx_ready`=1 one cycle after release.
  - The next send of 0x00 produces a clean frame.
- Change `tx_data` and pulse `tx_valid` while busy: the transmitted frame is unchanged and no extra handshake occurs.
